// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-line fetch requester.
// The Sysbus encodings fall back to local defaults when the system header is absent.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN
  } fetch_state_t;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = 8;

  localparam logic [12:0] READ_TAG = {`SYSBUS_READ, `SYSBUS_MEMORY, 8'b0};

endpackage

// File: rtl/line_buffer.sv
// One-line response buffer: registered write port, asynchronous read port.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = fetch_pkg::BEATS,
  localparam int unsigned IdxW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IdxW-1:0]       wr_idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IdxW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wdata;
    end
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/fetch_requester.sv
// Sequential instruction-line prefetcher: requests 64-byte lines over Sysbus,
// buffers the 8-beat burst and hands beats to the fetch stage under stall control.
module fetch_requester #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BUS_DATA_WIDTH-1:0] entry,
  input  logic                      stop,
  input  logic                      stall,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      fetch_en,
  output logic [BUS_DATA_WIDTH-1:0] data,
  output logic [BUS_DATA_WIDTH-1:0] fetch_pc,
  output logic                      idle
);

  import fetch_pkg::*;

  localparam int unsigned IdxW = $clog2(BEATS);
  localparam int unsigned OffW = IdxW + 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);

  fetch_state_t state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [IdxW-1:0]           wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]           rd_idx_q, rd_idx_d;
  logic                      stop_pend_q, stop_pend_d;

  logic                      beat_wr, beat_rd, last_wr, last_rd;
  logic [BUS_DATA_WIDTH-1:0] buf_rdata;
  logic                      unused_bits;

  assign unused_bits = ^{bus_resptag, entry[2:0]};

  assign beat_wr = (state_q == RESP) && bus_respcyc;
  assign beat_rd = (state_q == DRAIN) && !stall;
  assign last_wr = beat_wr && (wr_idx_q == LastIdx);
  assign last_rd = beat_rd && (rd_idx_q == LastIdx);

  line_buffer #(
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .DEPTH      (BEATS)
  ) u_line_buffer (
    .clk    (clk),
    .we     (beat_wr),
    .wr_idx (wr_idx_q),
    .wdata  (bus_resp),
    .rd_idx (rd_idx_q),
    .rdata  (buf_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start)      state_d = REQ;
      REQ:   if (bus_reqack) state_d = RESP;
      RESP:  if (last_wr)    state_d = DRAIN;
      DRAIN: if (last_rd)    state_d = stop_pend_q ? IDLE : REQ;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    line_addr_d = line_addr_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          line_addr_d = {entry[BUS_DATA_WIDTH-1:OffW], OffW'(0)};
          rd_idx_d    = entry[OffW-1:3];
        end
      end
      REQ:  if (bus_reqack) wr_idx_d = '0;
      RESP: if (beat_wr)    wr_idx_d = wr_idx_q + IdxW'(1);
      DRAIN: begin
        if (beat_rd) begin
          rd_idx_d = rd_idx_q + IdxW'(1);
        end
        if (last_rd && !stop_pend_q) begin
          line_addr_d = line_addr_q + BUS_DATA_WIDTH'(LINE_BYTES);
          rd_idx_d    = '0;
        end
      end
      default: ;
    endcase
    // A stop arriving on the final consume of a stopping line must not survive into IDLE.
    if (state_q == DRAIN && last_rd && stop_pend_q) begin
      stop_pend_d = 1'b0;
    end else if (stop && state_q != IDLE) begin
      stop_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_addr_q <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      line_addr_q <= line_addr_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Output logic
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    fetch_en    = 1'b0;
    data        = '0;
    fetch_pc    = '0;
    idle        = (state_q == IDLE);
    unique case (state_q)
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = line_addr_q;
        bus_reqtag = BUS_TAG_WIDTH'(READ_TAG);
      end
      RESP: bus_respack = bus_respcyc;
      DRAIN: begin
        fetch_en = 1'b1;
        data     = buf_rdata;
        fetch_pc = line_addr_q + BUS_DATA_WIDTH'({rd_idx_q, 3'b000});
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fetch_requester.md
Name: fetch_requester

Overview:
- Bus-side initiator that generates the instruction stream consumed by the fetch stage.
- Issues Sysbus read requests for 64-byte instruction lines and collects the 8-beat response burst into a line buffer.
- Presents the buffered beats one at a time as fetch_en/data, with downstream stall back-pressure.
- Prefetches lines sequentially until told to stop; sits between the Sysbus port and the fetch stage.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus data, addresses and output beats.
- BUS_TAG_WIDTH, 13, width of Sysbus request/response tags.
- BEATS, 8, beats per line; line size = BEATS*8 bytes = 64.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin fetching at entry (honoured only in IDLE)
- entry  in  64  start PC; must be 8-byte aligned
- stop  in  1  pulse: finish draining the current line, then go IDLE
- stall  in  1  downstream not ready; the current beat is held
- bus_reqcyc  out  1  request valid
- bus_req  out  64  request address (line aligned)
- bus_reqtag  out  13  {`SYSBUS_READ, `SYSBUS_MEMORY, 8'b0}
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  64  response beat data
- bus_resptag  in  13  response tag; ignored
- bus_respack  out  1  response beat accepted
- fetch_en  out  1  data valid toward fetch stage
- data  out  64  current beat (two instructions, low word first)
- fetch_pc  out  64  byte address of the current beat
- idle  out  1  FSM in IDLE

Behaviour:
- Reset:
  - State IDLE; line_addr = 0; wr_idx = 0; rd_idx = 0; stop_pend = 0.
  - All outputs 0 except idle = 1.
- States: IDLE, REQ, RESP, DRAIN.
- IDLE:
  - On start: line_addr <= {entry[63:6], 6'b0}; rd_idx <= entry[5:3]; go to REQ.
  - stop is ignored in IDLE.
- REQ:
  - bus_reqcyc = 1; bus_req = line_addr; tag as above. All three are held stable until bus_reqack.
  - On bus_reqack: go to RESP with wr_idx = 0. bus_reqcyc falls in the next cycle.
- RESP:
  - bus_respack = bus_respcyc (combinational, RESP state only).
  - Each beat with bus_respcyc = 1: buffer[wr_idx] <= bus_resp; wr_idx++.
  - Gaps (bus_respcyc = 0) are tolerated without limit.
  - On accepting beat BEATS-1: go to DRAIN.
- DRAIN:
  - Outputs (combinational from registers): fetch_en = 1; data = buffer[rd_idx]; fetch_pc = line_addr + 8*rd_idx.
  - A beat is consumed when fetch_en && !stall; then rd_idx++.
  - While stall = 1, data and fetch_pc are held.
  - On consuming beat BEATS-1:
    - If stop_pend: go to IDLE and clear stop_pend.
    - Otherwise: line_addr += 64 (wraps modulo 2^64); rd_idx = 0; go to REQ.
- First line:
  - Beats below entry[5:3] are fetched but never presented.
  - Latency from start to first fetch_en is at least 3 + BEATS cycles (start, REQ, ack, BEATS beats).
- stop:
  - Any pulse while not IDLE sets stop_pend.
  - The line in REQ or RESP is still completed and drained; no further request is issued.
- start while not IDLE is ignored.
- bus_respcyc outside RESP: bus_respack = 0 and the data is discarded.
- bus_respcyc in the same cycle as bus_reqack: the beat is ignored, because the FSM is still in REQ.
- Reset mid-burst: returns to IDLE immediately. Remaining response beats get no ack and write nothing.
- idle = (state == IDLE).

Decomposition:
- Shared package (fetch_pkg):
  - state enum fetch_state_t {IDLE, REQ, RESP, DRAIN};
  - LINE_BYTES = 64;
  - BEATS = 8;
  - READ_TAG constant built from the Sysbus defines.
- Sub-module line_buffer: BEATS x 64 register array with a write port (we, wr_idx, wdata) and an asynchronous read port (rd_idx). Instantiated once.

Test Plan:
- Aligned start: reset, start with entry = 0x1000, ack after 2 cycles, 8 back-to-back beats D0..D7 -> bus_req = 0x1000 stable until ack; data = D0..D7 with fetch_pc = 0x1000..0x1038; next request at 0x1040.
- Misaligned entry: entry = 0x2018 -> request 0x2000; first fetch_en presents beat 3 with fetch_pc = 0x2018; 5 beats presented, then request 0x2040.
- Stall and gaps: stall held high 4 cycles on beat 2; respcyc gaps between beats -> beat 2 data stays constant while stalled; no beat lost or duplicated; respack only with respcyc.
- Stop mid-response: stop pulses during RESP of line 0x3000 -> all 8 beats drained, then idle = 1 and no bus_reqcyc.
- Reset mid-burst: reset after beat 4 of 8, further respcyc beats -> bus_respack = 0, fetch_en = 0, idle = 1; a subsequent start at 0x4000 behaves as in the aligned-start case.
- Address wrap: entry = 0xFFFF_FFFF_FFFF_FFC0 -> second request is 0x0.
